tcdm_resp_router: RTL and testbench
===================================

// Module: tcdm_resp_router
// PURPOSE
//  Response-side companion of the round-robin request arbitration tree. Sits
//  between the tree's root and one TCDM slave port. On every granted request it
//  records the winning master index in an in-order ID FIFO. On every slave
//  response it pops that FIFO and steers the response back to the originating
//  master. It also back-pressures the tree when the FIFO is full.
// PARAMETERS
//  NumReq     32  number of masters behind the arbiter (>=1)
//  DataWidth  32  response data width
//  Depth      4   max outstanding transactions (>=1); ID FIFO depth
//  WriteResp  1   1: writes return a response and are tracked; 0: writes are not tracked
//  IdxWidth   localparam = (NumReq>1) ? $clog2(NumReq) : 1
// PORTS
//  clk_i        in   1               clock
//  rst_ni       in   1               asynchronous reset, active-low
//  req_i        in   1               request from arbiter root (arbiter req_o)
//  we_i         in   1               write enable of the arbitrated request
//  idx_i        in   IdxWidth        winning master index (arbiter idx_o, SelIdxOut=1)
//  gnt_o        out  1               grant back to arbiter root (arbiter gnt_i)
//  req_o        out  1               request to slave
//  gnt_i        in   1               grant from slave
//  rvalid_i     in   1               slave response valid
//  rdata_i      in   DataWidth       slave response data
//  rvalid_o     out  NumReq          one-hot response valid per master
//  rdata_o      out  DataWidth       response data, broadcast to all masters
//  outstanding_o out $clog2(Depth+1) current FIFO fill level
//  err_o        out  1               sticky: response received with no outstanding ID
// BEHAVIOUR
//  - Reset (async, rst_ni=0): FIFO empty, pointers 0, rvalid_o='0, rdata_o='0,
//    outstanding_o=0, err_o=0. Reset mid-operation drops all outstanding IDs.
//    Later responses to those requests raise err_o.
//  - full = (count==Depth). Gating (combinational):
//    req_o = req_i & ~full; gnt_o = gnt_i & ~full.
//    full is computed from registered count only; a same-cycle pop does NOT
//    unblock a push (no rvalid_i->gnt_o path).
//  - push = req_i & gnt_i & ~full & (WriteResp | ~we_i). It writes idx_i at wr_ptr.
//  - pop = rvalid_i & (count!=0). It reads the entry at rd_ptr.
//  - No bypass: a response never matches a request granted in the same cycle.
//    Slave latency is >=1.
//  - Pointers wrap from Depth-1 to 0. Depth need not be a power of 2.
//  - count_d = count + push - pop; simultaneous push and pop leaves count unchanged.
//  - Response path is registered, latency 1 cycle:
//    rvalid_o <= pop ? (1 << head_idx) : '0.
//    rdata_o <= rvalid_i ? rdata_i : rdata_o (holds last value otherwise).
//  - rvalid_i while count==0: no pop, rvalid_o='0 next cycle, err_o<=1.
//    err_o stays set until reset.
//  - head_idx >= NumReq (only possible for non-power-of-2 NumReq with corrupt
//    input): rvalid_o='0; this case is not flagged.
//  - outstanding_o = count (registered).
//  - Assertions: idx_i < NumReq whenever push; rvalid_o is onehot0.
// TESTING
//  1. Reset, NumReq=4, Depth=4: grant idx 2 (read) at cycle t, rvalid_i at t+2
//     with rdata 0xA5A5 -> rvalid_o=4'b0100, rdata_o=0xA5A5 at t+3;
//     outstanding 1 then 0.
//  2. Grant idx 0,3,1 back-to-back, then 3 responses -> rvalid_o
//     0001,1000,0010 in order; FIFO wraps.
//  3. Fill to Depth=4 without responses, then req_i=1, gnt_i=1 -> gnt_o=0,
//     req_o=0, no push. A response in the same cycle pops; gnt_o=1 next cycle.
//  4. count=2, push idx 1 and pop in the same cycle -> outstanding_o stays 2;
//     order is preserved.
//  5. WriteResp=0: granted write (we_i=1) -> no push, outstanding_o=0.
//     A stray rvalid_i -> err_o=1, rvalid_o='0.
//  6. Assert rst_ni low with 3 outstanding, release, send rvalid_i ->
//     err_o=1, no rvalid_o.

Source files
------------

// File: rtl/tcdm_resp_router.sv
`default_nettype none
// ============================================================================
//  Module      : tcdm_resp_router
//  Description : Response router for a round-robin request arbitration tree.
//                Records the winning master index of each granted request in
//                an in-order ID FIFO and steers slave responses back to the
//                originating master. Back-pressures the tree when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module tcdm_resp_router #(
  parameter int unsigned NumReq    = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter bit          WriteResp = 1'b1,
  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CNT_WIDTH = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // arbiter root side
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [IdxWidth-1:0]  idx_i,
  output logic                 gnt_o,
  // slave side
  output logic                 req_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [DataWidth-1:0] rdata_i,
  // master response side
  output logic [NumReq-1:0]    rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  // status
  output logic [CNT_WIDTH-1:0] outstanding_o,
  output logic                 err_o
);

  localparam int unsigned PTR_WIDTH = (Depth > 1) ? $clog2(Depth) : 1;

  logic [IdxWidth-1:0]  id_mem [Depth];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [IdxWidth-1:0]  head_idx;
  logic [NumReq-1:0]    rvalid_d;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never releases back-pressure combinationally.
  assign full  = (count == CNT_WIDTH'(Depth));
  assign empty = (count == '0);

  assign req_o = req_i & ~full;
  assign gnt_o = gnt_i & ~full;

  // Untracked writes (WriteResp=0) are granted but never enter the FIFO.
  assign push = req_i & gnt_i & ~full & (WriteResp | ~we_i);
  assign pop  = rvalid_i & ~empty;

  assign head_idx      = id_mem[rd_ptr];
  assign outstanding_o = count;

  // Decode the head index into a one-hot valid; out-of-range indices give '0.
  always_comb begin
    rvalid_d = '0;
    if (pop) begin
      for (int i = 0; i < int'(NumReq); i++) begin
        if (head_idx == IdxWidth'(i)) rvalid_d[i] = 1'b1;
      end
    end
  end

  // ID storage; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= idx_i;
  end

  // FIFO pointers and fill level; pointers wrap at Depth-1 (any Depth).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_WIDTH'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_WIDTH'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered response path: one cycle from rvalid_i to rvalid_o/rdata_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= rvalid_d;
      if (rvalid_i) rdata_o <= rdata_i;
    end
  end

  // Sticky error on a response that has no outstanding ID to match.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (rvalid_i && empty) begin
      err_o <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  a_idx_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   push |-> (32'(idx_i) < NumReq));
  a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     $onehot0(rvalid_o));
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcdm_resp_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tcdm_resp_router
//  Description : Self-checking bench for tcdm_resp_router. Instance A:
//                NumReq=4, Depth=4, WriteResp=1. Instance B: NumReq=3,
//                Depth=3, WriteResp=0 (non-power-of-2 wrap, untracked writes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_resp_router;

  logic clk;
  logic rst_n;

  // instance A stimulus / observation
  logic        a_req, a_we, a_sgnt, a_srvalid;
  logic [1:0]  a_idx;
  logic [31:0] a_srdata;
  logic        a_mgnt, a_sreq, a_err;
  logic [3:0]  a_rvalid;
  logic [31:0] a_rdata;
  logic [2:0]  a_outst;

  // instance B stimulus / observation
  logic        b_req, b_we, b_sgnt, b_srvalid;
  logic [1:0]  b_idx;
  logic [15:0] b_srdata;
  logic        b_mgnt, b_sreq, b_err;
  logic [2:0]  b_rvalid;
  logic [15:0] b_rdata;
  logic [1:0]  b_outst;

  int checks = 0;
  int errors = 0;

  // reference model state: in-order queues of master indices
  int          qa[$];
  int          qb[$];
  logic [3:0]  ea_rvalid;
  logic [31:0] ea_rdata;
  bit          ea_err;
  logic [2:0]  eb_rvalid;
  logic [15:0] eb_rdata;
  bit          eb_err;

  tcdm_resp_router #(.NumReq(4), .DataWidth(32), .Depth(4), .WriteResp(1'b1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(a_req), .we_i(a_we), .idx_i(a_idx), .gnt_o(a_mgnt),
    .req_o(a_sreq), .gnt_i(a_sgnt), .rvalid_i(a_srvalid), .rdata_i(a_srdata),
    .rvalid_o(a_rvalid), .rdata_o(a_rdata), .outstanding_o(a_outst), .err_o(a_err)
  );

  tcdm_resp_router #(.NumReq(3), .DataWidth(16), .Depth(3), .WriteResp(1'b0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(b_req), .we_i(b_we), .idx_i(b_idx), .gnt_o(b_mgnt),
    .req_o(b_sreq), .gnt_i(b_sgnt), .rvalid_i(b_srvalid), .rdata_i(b_srdata),
    .rvalid_o(b_rvalid), .rdata_o(b_rdata), .outstanding_o(b_outst), .err_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    ea_rvalid = '0; ea_rdata = '0; ea_err = 1'b0;
    eb_rvalid = '0; eb_rdata = '0; eb_err = 1'b0;
  endtask

  task automatic check_regs();
    check("a_rvalid", a_rvalid, ea_rvalid);
    check("a_rdata",  a_rdata,  ea_rdata);
    check("a_outst",  a_outst,  qa.size());
    check("a_err",    a_err,    ea_err);
    check("b_rvalid", b_rvalid, eb_rvalid);
    check("b_rdata",  b_rdata,  eb_rdata);
    check("b_outst",  b_outst,  qb.size());
    check("b_err",    b_err,    eb_err);
  endtask

  // One clock: check gating before the edge, advance the model at the edge,
  // check the registered outputs just after it.
  task automatic step();
    bit full_a, full_b;
    int h;
    #2;
    full_a = (qa.size() == 4);
    full_b = (qb.size() == 3);
    check("a_gnt_o", a_mgnt, a_sgnt & ~full_a);
    check("a_req_o", a_sreq, a_req & ~full_a);
    check("b_gnt_o", b_mgnt, b_sgnt & ~full_b);
    check("b_req_o", b_sreq, b_req & ~full_b);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      ea_rvalid = '0;
      if (a_srvalid) begin
        ea_rdata = a_srdata;
        if (qa.size() == 0) ea_err = 1'b1;
        else begin
          h = qa.pop_front();
          ea_rvalid = 4'(1 << h);
        end
      end
      if (a_req && a_sgnt && !full_a) qa.push_back(int'(a_idx));
      eb_rvalid = '0;
      if (b_srvalid) begin
        eb_rdata = b_srdata;
        if (qb.size() == 0) eb_err = 1'b1;
        else begin
          h = qb.pop_front();
          if (h < 3) eb_rvalid = 3'(1 << h);
        end
      end
      if (b_req && b_sgnt && !full_b && !b_we) qb.push_back(int'(b_idx));
    end
    #1;
    check_regs();
  endtask

  task automatic set_a(input logic req, input logic gnt, input logic we, input logic [1:0] idx,
                       input logic rv, input logic [31:0] rd);
    a_req = req; a_sgnt = gnt; a_we = we; a_idx = idx; a_srvalid = rv; a_srdata = rd;
  endtask

  task automatic set_b(input logic req, input logic gnt, input logic we, input logic [1:0] idx,
                       input logic rv, input logic [15:0] rd);
    b_req = req; b_sgnt = gnt; b_we = we; b_idx = idx; b_srvalid = rv; b_srdata = rd;
  endtask

  initial begin
    set_a(0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0);
    model_reset();
    rst_n = 1'b0;
    step();
    step();
    check("rst_a_rvalid", a_rvalid, 4'b0000);
    check("rst_a_outst",  a_outst,  3'd0);
    check("rst_a_err",    a_err,    1'b0);
    rst_n = 1'b1;

    // 1: single read from master 2, response two cycles later
    set_a(1, 1, 0, 2, 0, 0); step();
    check("t1_outst_1", a_outst, 3'd1);
    set_a(0, 0, 0, 0, 0, 0); step();
    set_a(0, 0, 0, 0, 1, 32'hA5A5); step();
    check("t1_rvalid", a_rvalid, 4'b0100);
    check("t1_rdata",  a_rdata,  32'hA5A5);
    check("t1_outst_0", a_outst, 3'd0);
    set_a(0, 0, 0, 0, 0, 0); step();
    check("t1_rvalid_clr", a_rvalid, 4'b0000);
    check("t1_rdata_hold", a_rdata,  32'hA5A5);

    // 2: back-to-back grants 0,3,1 then three responses
    set_a(1, 1, 0, 0, 0, 0); step();
    set_a(1, 1, 1, 3, 0, 0); step();
    set_a(1, 1, 0, 1, 0, 0); step();
    set_a(0, 0, 0, 0, 1, 32'h11); step();
    check("t2_r0", a_rvalid, 4'b0001);
    set_a(0, 0, 0, 0, 1, 32'h22); step();
    check("t2_r1", a_rvalid, 4'b1000);
    set_a(0, 0, 0, 0, 1, 32'h33); step();
    check("t2_r2", a_rvalid, 4'b0010);

    // 3: fill, blocked grant, same-cycle pop does not unblock
    for (int i = 0; i < 4; i++) begin
      set_a(1, 1, 0, 2'(i), 0, 0); step();
    end
    check("t3_full", a_outst, 3'd4);
    set_a(1, 1, 0, 2, 0, 0); #1;
    check("t3_gnt_blk", a_mgnt, 1'b0);
    check("t3_req_blk", a_sreq, 1'b0);
    step();
    set_a(1, 1, 0, 2, 1, 32'h44); #1;
    check("t3_no_bypass", a_mgnt, 1'b0);
    step();
    check("t3_outst_3", a_outst, 3'd3);
    set_a(1, 1, 0, 3, 0, 0); #1;
    check("t3_gnt_back", a_mgnt, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      set_a(0, 0, 0, 0, 1, 32'(i)); step();
    end

    // 4: count=2, simultaneous push and pop
    set_a(1, 1, 0, 2, 0, 0); step();
    set_a(1, 1, 0, 0, 0, 0); step();
    set_a(1, 1, 0, 1, 1, 32'h55); step();
    check("t4_outst", a_outst, 3'd2);
    check("t4_r0", a_rvalid, 4'b0100);
    set_a(0, 0, 0, 0, 1, 32'h66); step();
    check("t4_r1", a_rvalid, 4'b0001);
    set_a(0, 0, 0, 0, 1, 32'h77); step();
    check("t4_r2", a_rvalid, 4'b0010);
    set_a(0, 0, 0, 0, 0, 0); step();

    // randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      set_a($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30,
            2'($urandom_range(0, 3)),
            (qa.size() > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 3),
            $urandom);
      b_we = $urandom_range(0, 99) < 35;
      set_b($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70, b_we,
            b_we ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2)),
            (qb.size() > 0) && ($urandom_range(0, 99) < 45), 16'($urandom));
      step();
    end
    set_a(0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0);
    step();

    // 6: async reset with 3 outstanding drops them; late response is an error
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      set_a(1, 1, 0, 2'(i + 1), 0, 0); step();
    end
    set_a(0, 0, 0, 0, 0, 0);
    check("t6_outst_3", a_outst, 3'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_outst", a_outst, 3'd0);
    check("t6_async_rdata", a_rdata, 32'd0);
    step();
    rst_n = 1'b1;
    set_a(0, 0, 0, 0, 1, 32'h99); step();
    check("t6_err", a_err, 1'b1);
    check("t6_no_rvalid", a_rvalid, 4'b0000);

    // 5: untracked write on B, then stray response
    set_a(0, 0, 0, 0, 0, 0);
    set_b(1, 1, 1, 2, 0, 0); step();
    check("t5_outst", b_outst, 2'd0);
    check("t5_err_clr", b_err, 1'b0);
    set_b(0, 0, 0, 0, 1, 16'hBEEF); step();
    check("t5_err", b_err, 1'b1);
    check("t5_no_rvalid", b_rvalid, 3'b000);
    set_b(0, 0, 0, 0, 0, 0); step();
    check("t5_err_sticky", b_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
